axppa_toa_arbiter: RTL and testbench

- Shares one registered three-operand approximate adder among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Tags each issued operation and re-aligns the adder's fixed-latency sum with its requester ID and an exact reference sum.
- Buffers results in a credit-protected output FIFO and counts approximation errors for run-time accuracy monitoring.

---
 rtl/axppa_toa_arbiter.sv | 168 ++++++++++++++++
 tb/tb_axppa_toa_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axppa_toa_arbiter.sv
// Purpose : round-robin share of one registered three-operand approximate adder among NREQ requesters,
//           tagging each issue with its ID and exact sum, queueing results and counting approximation errors.
// Latency : LAT+1 cycles from handshake to resp_valid (empty FIFO); backpressure: issue stops when FIFO+in-flight reaches DEPTH.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready     per-requester handshake; req_ready is a combinational one-hot grant
//   req_a/b/c               packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a/b/c, add_sum      registered operands to / result from the external adder
//   resp_valid/resp_ready   FIFO head handshake; resp_id/resp_sum/resp_err describe the head
//   err_count               saturating count of results captured with err=1
module axppa_toa_arbiter #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4,
   parameter int LAT   = 1,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*WIDTH-1:0]      req_a,
   input  logic [NREQ*WIDTH-1:0]      req_b,
   input  logic [NREQ*WIDTH-1:0]      req_c,
   output logic [NREQ-1:0]            req_ready,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   output logic [WIDTH-1:0]           add_c,
   input  logic [WIDTH-1:0]           add_sum,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [$clog2(NREQ)-1:0]    resp_id,
   output logic [WIDTH-1:0]           resp_sum,
   output logic                       resp_err,
   output logic [15:0]                err_count
);

   localparam int IDW = $clog2(NREQ);
   localparam int AW  = $clog2(DEPTH);
   // wide enough to hold fifo_count + inflight without overflow
   localparam int CW  = $clog2(DEPTH + LAT + 2) + 1;

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   sel;
   logic [IDW-1:0]   cand;
   logic             found;
   logic             can_issue;
   logic             hs;
   logic [CW-1:0]    inflight;
   logic [WIDTH-1:0] op_a, op_b, op_c, exact;

   logic [LAT:0]     tag_vld;
   logic [IDW-1:0]   tag_id    [0:LAT];
   logic [WIDTH-1:0] tag_exact [0:LAT];

   logic [IDW-1:0]   mem_id  [0:DEPTH-1];
   logic [WIDTH-1:0] mem_sum [0:DEPTH-1];
   logic             mem_err [0:DEPTH-1];
   logic [AW-1:0]    wr_ptr, rd_ptr, head_idx;
   logic [AW:0]      fifo_count;
   logic             push, pop, cap_err;

   // ---------------- credit ----------------
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= LAT; i++) begin
         inflight = inflight + CW'(tag_vld[i]);
      end
   end

   // A pop only lowers fifo_count at the next edge, so credit returns one cycle later.
   assign can_issue = (CW'(fifo_count) + inflight) < CW'(DEPTH);

   // ---------------- round-robin arbitration ----------------
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // reset gating keeps the grant low for the whole time reset is held
   assign hs = found & can_issue & reset;

   always_comb begin
      req_ready = '0;
      if (hs) req_ready[sel] = 1'b1;
   end

   assign op_a  = req_a[int'(sel)*WIDTH +: WIDTH];
   assign op_b  = req_b[int'(sel)*WIDTH +: WIDTH];
   assign op_c  = req_c[int'(sel)*WIDTH +: WIDTH];
   assign exact = op_a + op_b + op_c;

   // ---------------- issue + tag pipeline ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr     <= IDW'(NREQ - 1);
         add_a   <= '0;
         add_b   <= '0;
         add_c   <= '0;
         tag_vld <= '0;
         for (int i = 0; i <= LAT; i++) begin
            tag_id[i]    <= '0;
            tag_exact[i] <= '0;
         end
      end else begin
         if (hs) begin
            ptr   <= sel;
            add_a <= op_a;
            add_b <= op_b;
            add_c <= op_c;
         end
         // a bubble (valid=0) enters whenever no handshake happens
         tag_vld[0]   <= hs;
         tag_id[0]    <= sel;
         tag_exact[0] <= exact;
         for (int i = 1; i <= LAT; i++) begin
            tag_vld[i]   <= tag_vld[i-1];
            tag_id[i]    <= tag_id[i-1];
            tag_exact[i] <= tag_exact[i-1];
         end
      end
   end

   // ---------------- capture + output FIFO ----------------
   assign push    = tag_vld[LAT];
   assign cap_err = (add_sum != tag_exact[LAT]);
   assign pop     = resp_valid & resp_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         err_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_id[i]  <= '0;
            mem_sum[i] <= '0;
            mem_err[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            mem_id[wr_ptr]  <= tag_id[LAT];
            mem_sum[wr_ptr] <= add_sum;
            mem_err[wr_ptr] <= cap_err;
            wr_ptr          <= wr_ptr + AW'(1);
            if (cap_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign resp_valid = (fifo_count != '0);

   // When empty, keep showing the most recently popped slot so the outputs hold.
   assign head_idx = resp_valid ? rd_ptr : (rd_ptr - AW'(1));
   assign resp_id  = mem_id[head_idx];
   assign resp_sum = mem_sum[head_idx];
   assign resp_err = mem_err[head_idx];

endmodule

// File: tb/tb_axppa_toa_arbiter.sv
// Purpose : directed scoreboard bench for axppa_toa_arbiter with a behavioural registered adder.
// Latency : adder model has LAT=1 (sum registered one edge after operands).
// Checks  : grants checked in stimulus, responses popped and compared by an independent monitor.
module tb_axppa_toa_arbiter;
   localparam int WIDTH = 16;
   localparam int NREQ  = 4;
   localparam int LAT   = 1;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_valid;
   logic [63:0] req_a, req_b, req_c;
   logic [3:0]  req_ready;
   logic [15:0] add_a, add_b, add_c, add_sum;
   logic        resp_valid, resp_ready;
   logic [1:0]  resp_id;
   logic [15:0] resp_sum;
   logic        resp_err;
   logic [15:0] err_count;
   bit          err_mode;

   int n_checks = 0;
   int n_errors = 0;
   logic [18:0] exp_q[$];   // {id, sum, err}

   logic [15:0] a_tab   [0:3] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
   logic [15:0] b_tab   [0:3] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
   logic [15:0] sum_tab [0:3] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};

   axppa_toa_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_sum(add_sum),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_sum(resp_sum), .resp_err(resp_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // behavioural adder: one registered stage, optional bit-0 corruption when add_a is all ones
   always @(posedge clk)
      add_sum <= (add_a + add_b + add_c) ^ {15'd0, (err_mode && add_a == 16'hFFFF)};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // response monitor
   always @(negedge clk) begin : mon
      logic [18:0] e;
      if (reset && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: got id %0d sum %0h err %0b, scoreboard empty", resp_id, resp_sum, resp_err);
         end else begin
            e = exp_q.pop_front();
            check("resp", {13'd0, resp_id, resp_sum, resp_err}, {13'd0, e});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_table_ops();
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = a_tab[i];
         req_b[i*16 +: 16] = b_tab[i];
         req_c[i*16 +: 16] = 16'h0001;
      end
   endtask

   task automatic issue_one(input int id, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] exp_sum, input logic exp_err);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[id*16 +: 16] = a;
      req_b[id*16 +: 16] = b;
      req_c[id*16 +: 16] = c;
      @(negedge clk);
      check("grant_single", {28'd0, req_ready}, {28'd0, 4'b0001 << id});
      exp_q.push_back({2'(id), exp_sum, exp_err});
      tick();
      req_valid = '0;
   endtask

   task automatic drain();
      resp_ready = 1'b1;
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);
      @(negedge clk);
      check("idle_resp_valid", {31'd0, resp_valid}, 0);
      tick();
   endtask

   task automatic sat_burst(input int n);
      int got;
      got = 0;
      req_a[15:0] = 16'hFFFF;
      req_b[15:0] = 16'h0000;
      req_c[15:0] = 16'h0000;
      req_valid   = 4'b0001;
      for (int k = 0; k < n + 50 && got < n; k++) begin
         @(negedge clk);
         if (req_ready[0]) begin
            got++;
            exp_q.push_back({2'd0, 16'hFFFE, 1'b1});
         end
         tick();
         if (got == n) req_valid = '0;
      end
      req_valid = '0;
      check("sat_issued", got, n);
   endtask

   initial begin
      int g;
      int bp_g [0:5] = '{1, 2, 3, 0, -1, -1};
      req_valid  = 4'hF;
      req_a      = '0;
      req_b      = '0;
      req_c      = '0;
      resp_ready = 1'b0;
      err_mode   = 1'b0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", {31'd0, resp_valid}, 0);
      check("rst_resp_id",    {30'd0, resp_id}, 0);
      check("rst_resp_sum",   {16'd0, resp_sum}, 0);
      check("rst_resp_err",   {31'd0, resp_err}, 0);
      check("rst_err_count",  {16'd0, err_count}, 0);
      check("rst_add_a",      {16'd0, add_a}, 0);
      check("rst_req_ready",  {28'd0, req_ready}, 0);
      req_valid = '0;
      tick();
      reset = 1'b1;
      tick();

      // ---- single request, latency ----
      resp_ready = 1'b1;
      req_a[15:0] = 16'd5;
      req_valid   = 4'b0001;
      @(negedge clk);
      check("single_grant", {28'd0, req_ready}, 32'h1);
      exp_q.push_back({2'd0, 16'h0005, 1'b0});
      tick();                       // E0
      req_valid = '0;
      @(negedge clk);
      check("single_add_a", {16'd0, add_a}, 32'h5);
      check("lat_e0", {31'd0, resp_valid}, 0);
      @(negedge clk);
      check("lat_e1", {31'd0, resp_valid}, 0);
      @(negedge clk);
      check("lat_e2", {31'd0, resp_valid}, 1);
      drain();

      // ---- round robin, all valid, resp_ready=1 (ptr now 0, so 1 is next) ----
      set_table_ops();
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         g = (k + 1) % 4;
         @(negedge clk);
         check("rr_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << g});
         exp_q.push_back({2'(g), sum_tab[g], 1'b0});
         tick();
      end
      req_valid = '0;
      drain();

      // ---- backpressure / credit limit ----
      resp_ready = 1'b0;
      req_valid  = 4'hF;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bp_g[k] >= 0) begin
            check("bp_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << bp_g[k]});
            exp_q.push_back({2'(bp_g[k]), sum_tab[bp_g[k]], 1'b0});
         end else begin
            check("bp_blocked", {28'd0, req_ready}, 0);
         end
         tick();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("bp_pop_cycle_blocked", {28'd0, req_ready}, 0);
      tick();
      resp_ready = 1'b0;
      @(negedge clk);
      check("bp_regrant", {28'd0, req_ready}, 32'h2);
      exp_q.push_back({2'd1, sum_tab[1], 1'b0});
      tick();
      @(negedge clk);
      check("bp_blocked_again", {28'd0, req_ready}, 0);
      req_valid = '0;
      drain();

      // ---- error detection ----
      err_mode = 1'b1;
      issue_one(2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b1);
      issue_one(2, 16'h0001, 16'h0001, 16'h0001, 16'h0003, 1'b0);
      drain();
      check("err_count_one", {16'd0, err_count}, 1);

      // ---- wrap-around and saturation ----
      issue_one(1, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 1'b0);
      drain();
      check("err_count_wrap", {16'd0, err_count}, 1);
      sat_burst(65533);
      drain();
      check("err_count_fffe", {16'd0, err_count}, 32'hFFFE);
      sat_burst(3);
      drain();
      check("err_count_sat", {16'd0, err_count}, 32'hFFFF);

      // ---- reset mid-flight ----
      err_mode = 1'b0;
      set_table_ops();
      resp_ready = 1'b0;
      req_valid  = 4'b1000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("mf_grant", {28'd0, req_ready}, 32'h8);
         exp_q.push_back({2'd3, sum_tab[3], 1'b0});
         tick();
      end
      tick();                        // 3 in FIFO, 1 in flight
      check("mf_resp_valid_pre", {31'd0, resp_valid}, 1);
      reset = 1'b0;
      #1;
      check("mf_rst_resp_valid", {31'd0, resp_valid}, 0);
      check("mf_rst_req_ready", {28'd0, req_ready}, 0);
      exp_q.delete();
      tick();
      check("mf_rst_err_count", {16'd0, err_count}, 0);
      reset = 1'b1;
      req_valid  = 4'hF;
      resp_ready = 1'b1;
      @(negedge clk);
      check("mf_first_grant", {28'd0, req_ready}, 32'h1);
      exp_q.push_back({2'd0, sum_tab[0], 1'b0});
      tick();
      req_valid = '0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
